data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Responder end of the CPU data-memory interface: accepts enable/read/write/address/data requests from the core and answers with read data and a completion strobe.
- Word-addressed synchronous RAM with a configurable access latency, request edge detection, and error/overrun reporting.
- Sits outside the core, on the DM_* wires, alongside the instruction memory.

Parameters:
DATA_WIDTH, 32, word width of DM_in/DM_out
ADDR_WIDTH, 12, width of DM_address (word address)
DEPTH, 4096, number of implemented words; must be <= 2**ADDR_WIDTH
LATENCY, 1, cycles from request sample to completion; legal range 1..15

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
DM_enable  input  1  request strobe; a new request is its rising edge
DM_read  input  1  read request qualifier
DM_write  input  1  write request qualifier
DM_address  input  ADDR_WIDTH  word address
DM_in  input  DATA_WIDTH  write data
DM_out  output  DATA_WIDTH  read data, held until next read completes
DM_ready  output  1  one-cycle completion pulse
DM_busy  output  1  high while a request is in flight
DM_error  output  1  one-cycle pulse with DM_ready on an illegal request
DM_overrun  output  1  sticky: request edge arrived while busy

Behaviour:
- Reset (sync, active-high): state IDLE, counter 0, DM_out=0, DM_ready=0, DM_busy=0, DM_error=0, DM_overrun=0, enable history register set to 1.
  - Setting the history register to 1 means an enable held high through reset is not taken as a request.
  - RAM contents are not reset.
- Request detect: req = DM_enable & ~enable_q, where enable_q is DM_enable registered every cycle.
  - A level-held enable never retriggers.
  - An enable edge with DM_read=0 and DM_write=0 is a no-op: no state change, no ready.
- FSM states: IDLE, BUSY.
  - IDLE + req with read or write: capture address, data and op; counter=LATENCY-1; go to BUSY; DM_busy=1 from the next cycle.
  - BUSY, counter!=0: decrement.
  - BUSY, counter==0: perform the access, pulse DM_ready=1 for exactly the next cycle, go to IDLE, DM_busy=0.
  - Completion is therefore LATENCY edges after the sampling edge.
  - A new request edge may be accepted in the same cycle DM_ready is high (back-to-back).
- Read: DM_out <= mem[addr] on the completion edge; DM_out holds that value until the next read completes (writes do not change DM_out).
- Write: mem[addr] <= captured DM_in on the completion edge. Read-after-write to the same address returns the new data.
- Illegal requests: read and write both high, or addr >= DEPTH.
  - No RAM access; DM_out <= 0 for the read or dual case.
  - DM_ready and DM_error both pulse at normal completion time.
- Overrun: a req edge while in BUSY is dropped and sets DM_overrun=1 until reset. The in-flight request completes unaffected.
- Captured request fields are stable during BUSY; input changes during BUSY are ignored.
- Reset mid-operation: the in-flight request is aborted. A pending write is not performed and no DM_ready is issued.

Test Plan:
- LATENCY=1: write 0xDEADBEEF to addr 0x005 (enable rises with write=1), then read 0x005. Required: DM_ready one cycle after each sampling edge; DM_out=0xDEADBEEF; DM_busy high one cycle per access.
- LATENCY=4: read addr 0x010 previously written 0x12345678. Required: DM_busy high for 4 cycles, DM_ready exactly 4 edges after the sample, DM_out changes only on the completion edge.
- Enable held high for 10 cycles with read=1. Required: exactly one DM_ready. Then a second edge within BUSY (LATENCY=4) sets DM_overrun=1, which stays 1 until reset.
- read=write=1 at addr 0x001, and DEPTH=1024 with read of addr 0x400. Required: DM_ready+DM_error pulse together, DM_out=0, mem[0x001] unchanged.
- Write 0xA5A5A5A5 to 0x020 with LATENCY=4, assert reset at cycle 2. Required: all outputs 0, no DM_ready, subsequent read of 0x020 returns the prior value. Enable held high through reset deassertion produces no request.
- Back-to-back: a write edge coincident with the previous read's DM_ready cycle is accepted. Required: both complete and DM_overrun stays 0.

Source files
------------

// File: rtl/data_memory_if.sv
// Request/response wires between the CPU data port and the data memory.
// The core side drives the request fields; the memory side answers with data and status strobes.
interface data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  DM_enable;
  logic                  DM_read;
  logic                  DM_write;
  logic [ADDR_WIDTH-1:0] DM_address;
  logic [DATA_WIDTH-1:0] DM_in;
  logic [DATA_WIDTH-1:0] DM_out;
  logic                  DM_ready;
  logic                  DM_busy;
  logic                  DM_error;
  logic                  DM_overrun;

  modport master (
    output DM_enable, DM_read, DM_write, DM_address, DM_in,
    input  DM_out, DM_ready, DM_busy, DM_error, DM_overrun
  );

  modport slave (
    input  DM_enable, DM_read, DM_write, DM_address, DM_in,
    output DM_out, DM_ready, DM_busy, DM_error, DM_overrun
  );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM, completes a request LATENCY edges after the enable rising edge is sampled.
// One request in flight; request edges arriving while busy are dropped and flagged as sticky overrun.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 1
) (
  input  logic          clock,
  input  logic          reset,
  data_memory_if.slave  dm
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q,   state_d;
  logic [3:0]            cnt_q,     cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] din_q,     din_d;
  logic                  rd_q,      rd_d;
  logic                  wr_q,      wr_d;
  logic                  enable_q,  enable_d;
  logic [DATA_WIDTH-1:0] out_q,     out_d;
  logic                  ready_q,   ready_d;
  logic                  busy_q,    busy_d;
  logic                  error_q,   error_d;
  logic                  overrun_q, overrun_d;

  logic                  req;
  logic                  illegal;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  assign req     = dm.DM_enable & ~enable_q;
  assign illegal = (rd_q & wr_q) | ({1'b0, addr_q} >= DEPTH_L);
  assign rd_data = mem[addr_q[IDX_W-1:0]];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    enable_d  = dm.DM_enable;
    out_d     = out_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    error_d   = 1'b0;
    overrun_d = overrun_q;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req && (dm.DM_read || dm.DM_write)) begin
          addr_d  = dm.DM_address;
          din_d   = dm.DM_in;
          rd_d    = dm.DM_read;
          wr_d    = dm.DM_write;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
          busy_d  = 1'b1;
        end
      end
      BUSY: begin
        if (req) overrun_d = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          error_d = illegal;
          // A dual read/write counts as a read for the purpose of clearing DM_out.
          if (illegal) begin
            if (rd_q) out_d = '0;
          end else if (rd_q) begin
            out_d = rd_data;
          end else begin
            mem_we = ~reset;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      din_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      enable_q  <= 1'b1;
      out_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      enable_q  <= enable_d;
      out_q     <= out_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[addr_q[IDX_W-1:0]] <= din_q;
  end

  assign dm.DM_out     = out_q;
  assign dm.DM_ready   = ready_q;
  assign dm.DM_busy    = busy_q;
  assign dm.DM_error   = error_q;
  assign dm.DM_overrun = overrun_q;
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: instance 0 at LATENCY=1/DEPTH=4096, instance 1 at LATENCY=4/DEPTH=1024.
// A shared request bus is steered to one instance at a time by sel.
module tb_data_memory;
  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        sel   = 1'b0;
  logic        en    = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [11:0] addr  = '0;
  logic [31:0] din   = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) i0 ();
  data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) i1 ();

  assign i0.DM_enable  = en & ~sel;
  assign i0.DM_read    = rd;
  assign i0.DM_write   = wr;
  assign i0.DM_address = addr;
  assign i0.DM_in      = din;
  assign i1.DM_enable  = en & sel;
  assign i1.DM_read    = rd;
  assign i1.DM_write   = wr;
  assign i1.DM_address = addr;
  assign i1.DM_in      = din;

  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(4096), .LATENCY(1)) u0 (
    .clock(clock), .reset(rst), .dm(i0.slave));
  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(1024), .LATENCY(4)) u1 (
    .clock(clock), .reset(rst), .dm(i1.slave));

  logic [31:0] out;
  logic        rdy, busy, err, ovr;
  assign out  = sel ? i1.DM_out     : i0.DM_out;
  assign rdy  = sel ? i1.DM_ready   : i0.DM_ready;
  assign busy = sel ? i1.DM_busy    : i0.DM_busy;
  assign err  = sel ? i1.DM_error   : i0.DM_error;
  assign ovr  = sel ? i1.DM_overrun : i0.DM_overrun;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Raise enable with the given op, then follow the request to its completion edge.
  task automatic access(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d,
                        input int lat, input logic e_err, input logic [31:0] prev,
                        input logic [31:0] exp);
    en = 1'b1; rd = r; wr = w; addr = a; din = d;
    tick();
    en = 1'b0; rd = 1'b0; wr = 1'b0; addr = a + 12'd1; din = ~d;
    for (int i = 0; i < lat; i++) begin
      check("busy_inflight", busy, 1);
      check("ready_early", rdy, 0);
      check("out_hold", out, prev);
      tick();
    end
    check("ready_pulse", rdy, 1);
    check("busy_done", busy, 0);
    check("error_flag", err, e_err);
    check("out_value", out, exp);
  endtask

  initial begin
    int cnt;

    rst = 1'b1;
    tick(); tick();
    check("rst_out", out, 0);
    check("rst_ready", rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_error", err, 0);
    check("rst_overrun", ovr, 0);
    rst = 1'b0;
    tick();

    // LATENCY=1: write then read back
    access(1'b0, 1'b1, 12'h005, 32'hDEADBEEF, 1, 1'b0, 32'h0, 32'h0);
    tick();
    check("ready_one_cycle", rdy, 0);
    access(1'b1, 1'b0, 12'h005, 32'h0, 1, 1'b0, 32'h0, 32'hDEADBEEF);

    // Held enable yields exactly one completion
    tick();
    en = 1'b1; rd = 1'b1; addr = 12'h005;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rdy) cnt++;
    end
    check("held_ready_count", cnt, 1);
    check("held_overrun", ovr, 0);
    en = 1'b0; rd = 1'b0;
    tick();

    // Edge with neither read nor write does nothing
    en = 1'b1;
    tick();
    check("noop_busy", busy, 0);
    tick();
    check("noop_ready", rdy, 0);
    en = 1'b0;
    tick();

    // LATENCY=4 instance
    sel = 1'b1;
    tick();
    access(1'b0, 1'b1, 12'h010, 32'h12345678, 4, 1'b0, 32'h0, 32'h0);
    access(1'b1, 1'b0, 12'h010, 32'h0, 4, 1'b0, 32'h0, 32'h12345678);
    tick();
    check("l4_ready_one_cycle", rdy, 0);

    // Illegal: dual op, then out-of-range address
    access(1'b0, 1'b1, 12'h001, 32'h11111111, 4, 1'b0, 32'h12345678, 32'h12345678);
    access(1'b1, 1'b1, 12'h001, 32'hFFFF0000, 4, 1'b1, 32'h12345678, 32'h0);
    tick();
    check("error_one_cycle", err, 0);
    access(1'b1, 1'b0, 12'h001, 32'h0, 4, 1'b0, 32'h0, 32'h11111111);
    access(1'b1, 1'b0, 12'h400, 32'h0, 4, 1'b1, 32'h11111111, 32'h0);

    // Reset in the middle of a write aborts it
    access(1'b0, 1'b1, 12'h020, 32'hCAFEF00D, 4, 1'b0, 32'h0, 32'h0);
    en = 1'b1; wr = 1'b1; addr = 12'h020; din = 32'hA5A5A5A5;
    tick();
    check("abort_busy", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    check("abort_out", out, 0);
    check("abort_busy_rst", busy, 0);
    check("abort_ready", rdy, 0);
    wr = 1'b0; rd = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_ready", rdy, 0);
      check("post_rst_busy", busy, 0);
    end
    en = 1'b0; rd = 1'b0;
    tick();

    // Read the survivor, then a write edge inside the ready cycle
    access(1'b1, 1'b0, 12'h020, 32'h0, 4, 1'b0, 32'h0, 32'hCAFEF00D);
    access(1'b0, 1'b1, 12'h030, 32'h00000055, 4, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
    access(1'b1, 1'b0, 12'h030, 32'h0, 4, 1'b0, 32'hCAFEF00D, 32'h00000055);
    check("b2b_overrun", ovr, 0);
    tick();

    // Second edge while busy: dropped, overrun sticks
    en = 1'b1; rd = 1'b1; addr = 12'h010;
    tick();
    en = 1'b0; addr = 12'h001;
    tick();
    check("ovr_before", ovr, 0);
    en = 1'b1;
    tick();
    check("ovr_set", ovr, 1);
    en = 1'b0; rd = 1'b0;
    tick();
    check("ovr_ready_early", rdy, 0);
    tick();
    check("ovr_ready", rdy, 1);
    check("ovr_out", out, 32'h12345678);
    for (int i = 0; i < 8; i++) tick();
    check("ovr_sticky", ovr, 1);
    check("ovr_no_extra_busy", busy, 0);
    rst = 1'b1;
    tick();
    check("ovr_cleared", ovr, 0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
